// File: rtl/bit_expander.sv
// bit_expander: builds a W-bit thermometer mask from a count, one bit per cycle.
// Ports: clk, rst (async high), data_in/carry_in/in_valid/in_ready request,
//   data_out/ovf_out/out_valid/out_ready result, busy. Define
//   BIT_EXPANDER_MSB_FIRST_EN to fill the mask from the MSB downward.
module bit_expander #(
  parameter int OUTPUTBITWIDTH = 16,
  parameter int COUNTBITWIDTH  = $clog2(OUTPUTBITWIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COUNTBITWIDTH-1:0]  data_in,
  input  logic                      carry_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUTPUTBITWIDTH-1:0] data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      ovf_out,
  output logic                      busy
);

  localparam int W  = OUTPUTBITWIDTH;
  localparam int CW = COUNTBITWIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUILD = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW:0] WMAX = (CW+1)'(W);
  localparam logic [CW:0] ONE  = (CW+1)'(1);

  logic [1:0]   state;
  logic [CW:0]  rem;
  logic [W-1:0] mask;
  logic         ovf;
  // Low while rst is high and for the first edge after release, so
  // in_ready stays low during reset without a path from rst.
  logic         live;

  logic [CW:0] req_v;
  logic [CW:0] req_t;
  logic        req_ovf;
  logic        accept;

  assign req_v   = {carry_in, data_in};
  assign req_ovf = req_v > WMAX;
  assign req_t   = req_ovf ? WMAX : req_v;

  assign in_ready  = (state == IDLE) && live;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign data_out  = mask;
  assign ovf_out   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      mask  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mask  <= '0;
            ovf   <= req_ovf;
            rem   <= req_t;
            state <= (req_t == '0) ? DONE : BUILD;
          end
        end
        BUILD: begin
`ifdef BIT_EXPANDER_MSB_FIRST_EN
          mask <= {1'b1, mask[W-1:1]};
`else
          mask <= {mask[W-2:0], 1'b1};
`endif
          rem <= rem - ONE;
          if (rem == ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_expander.sv
// tb_bit_expander: table, random and sequence checks for bit_expander.
// Expected masks come from a count-to-mask model, not the RTL structure.
module tb_bit_expander;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  data_in = '0;
  logic        carry_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        ovf_out;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  bit_expander #(.OUTPUTBITWIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_out(ovf_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          v;
    int          stall;
    logic [15:0] em;
    logic        eo;
    int          elat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v > W) ? W : v;
  endfunction

  // Count of set bits is min(V,W), packed against the fill end.
  function automatic logic [15:0] model_mask(input int v);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < sat(v); i++) begin
`ifdef BIT_EXPANDER_MSB_FIRST_EN
      m[W-1-i] = 1'b1;
`else
      m[i] = 1'b1;
`endif
    end
    return m;
  endfunction

  function automatic logic [15:0] orient(input logic [15:0] lsb_mask);
`ifdef BIT_EXPANDER_MSB_FIRST_EN
    return rev16(lsb_mask);
`else
    return lsb_mask;
`endif
  endfunction

  // Issues one request at a negedge and follows it through the handshake.
  task automatic do_req(input int v, input int stall, input logic [15:0] em,
                        input logic eo, input int elat);
    int n;
    logic [4:0] vb;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", in_ready, 1);
    vb = v[4:0];
    {carry_in, data_in} = vb;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, elat);
    check("mask", data_out, em);
    check("ovf", ovf_out, eo);
    check("busy_done", busy, 1);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      {carry_in, data_in} = 5'(i + 7);
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_mask", data_out, em);
      check("stall_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    check("post_hold", data_out, em);
    check("post_busy", busy, 0);
  endtask

  logic [15:0] got_q[$];
  bit collect = 1'b0;

  always @(negedge clk) begin
    if (collect && out_valid && out_ready) got_q.push_back(data_out);
  end

  initial begin
    int v;
    int n;
    tbl[0] = '{5, 0, 16'h001F, 1'b0, 5};
    tbl[1] = '{0, 0, 16'h0000, 1'b0, 0};
    tbl[2] = '{16, 0, 16'hFFFF, 1'b0, 16};
    tbl[3] = '{20, 0, 16'hFFFF, 1'b1, 16};
    tbl[4] = '{3, 10, 16'h0007, 1'b0, 3};
    tbl[5] = '{31, 0, 16'hFFFF, 1'b1, 16};
    tbl[6] = '{15, 2, 16'h7FFF, 1'b0, 15};
    tbl[7] = '{1, 1, 16'h0001, 1'b0, 1};

    repeat (3) @(negedge clk);
    check("rst_mask", data_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_ovf", ovf_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i].v, tbl[i].stall, orient(tbl[i].em), tbl[i].eo,
             tbl[i].elat);
    end

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 31));
      do_req(v, int'($urandom_range(0, 3)), model_mask(v), v > W, sat(v));
    end

    // Reset in the middle of a build.
    {carry_in, data_in} = 5'd12;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_mask", data_out, 0);
    check("mr_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    do_req(2, 0, orient(16'h0003), 1'b0, 2);

    // Back-to-back with in_valid held high.
    collect = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      {carry_in, data_in} = 5'(k);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    collect = 1'b0;
    check("b2b_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) check("b2b_mask", got_q[k], model_mask(k + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
